sram_bank_arbiter: RTL and testbench

- Parametrised successor to the single-cycle SRAM port mux.
- Arbitrates NUM_PORTS requesters (GEMM engines, ELEM, AXI in/out) onto NUM_BANKS single-port SRAM banks of the multi-bank SRAM array.
- Per-bank round-robin arbitration and a valid/ready handshake per port replace silent OR-combining of colliding enables.
- Tagged read-return pipeline routes bank read data back to the issuing port; saturating conflict counter for profiling.

---
 rtl/sram_bank_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sram_bank_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_arbiter.sv
// Multi-port to multi-bank SRAM arbiter: per-bank round-robin grant, registered bank
// issue, tagged read-return pipeline and a saturating stall counter.
module sram_bank_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned NUM_BANKS = 8,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BANK_LAT  = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_PORTS-1:0]                   p_req,
    input  logic [NUM_PORTS-1:0]                   p_we,
    input  logic [NUM_PORTS*$clog2(NUM_BANKS)-1:0] p_bank,
    input  logic [NUM_PORTS*ADDR_W-1:0]            p_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]            p_wdata,
    output logic [NUM_PORTS-1:0]                   p_ready,
    output logic [NUM_PORTS-1:0]                   p_rvalid,
    output logic [NUM_PORTS*DATA_W-1:0]            p_rdata,
    output logic [NUM_BANKS-1:0]                   bank_en,
    output logic [NUM_BANKS-1:0]                   bank_we,
    output logic [NUM_BANKS*ADDR_W-1:0]            bank_addr,
    output logic [NUM_BANKS*DATA_W-1:0]            bank_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]            bank_rdata,
    output logic [CNT_W-1:0]                       conflict_cnt,
    input  logic                                   clr_cnt
);

    localparam int unsigned BW   = $clog2(NUM_BANKS);
    localparam int unsigned PW   = $clog2(NUM_PORTS);
    localparam int unsigned SUMW = PW + 1;
    localparam int unsigned KW   = PW + 1;
    localparam int unsigned TD   = BANK_LAT + 1;
    localparam int unsigned SW   = CNT_W + 1;

    logic [NUM_PORTS-1:0] cand [NUM_BANKS];
    logic [NUM_PORTS-1:0] rot;
    logic [PW-1:0]        off;
    logic [SUMW-1:0]      gsum;
    logic [NUM_BANKS-1:0] gnt_vld;
    logic [PW-1:0]        gnt_id [NUM_BANKS];
    logic [PW-1:0]        rr_ptr [NUM_BANKS];
    logic [NUM_PORTS-1:0] ready_c;

    logic                 sel_we    [NUM_BANKS];
    logic [ADDR_W-1:0]    sel_addr  [NUM_BANKS];
    logic [DATA_W-1:0]    sel_wdata [NUM_BANKS];

    logic                 tag_vld [NUM_BANKS][TD];
    logic [PW-1:0]        tag_id  [NUM_BANKS][TD];
    logic [NUM_PORTS-1:0] rv_nxt;
    logic [NUM_PORTS*DATA_W-1:0] rd_nxt;

    logic [NUM_PORTS-1:0] stall;
    logic [KW-1:0]        nstall;
    logic [SW-1:0]        csum;

    // Per-bank round robin: rotate candidates by the pointer, pick the lowest set bit.
    always_comb begin
        gnt_vld = '0;
        ready_c = '0;
        rot     = '0;
        off     = '0;
        gsum    = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            gnt_id[b] = '0;
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                cand[b][p] = p_req[p] && (p_bank[p*BW +: BW] == BW'(b));
            end
            rot = NUM_PORTS'({cand[b], cand[b]} >> rr_ptr[b]);
            off = '0;
            for (int o = int'(NUM_PORTS) - 1; o >= 0; o--) begin
                if (rot[o]) off = PW'(o);
            end
            gsum = SUMW'(rr_ptr[b]) + SUMW'(off);
            if (gsum >= SUMW'(NUM_PORTS)) gsum = gsum - SUMW'(NUM_PORTS);
            gnt_vld[b] = |cand[b];
            gnt_id[b]  = gsum[PW-1:0];
        end
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (gnt_vld[b] && gnt_id[b] == PW'(p)) ready_c[p] = 1'b1;
            end
        end
    end

    // Ready is forced low while reset is held, even though it is combinational.
    assign p_ready = rst ? ready_c : '0;

    always_comb begin
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            sel_we[b]    = 1'b0;
            sel_addr[b]  = '0;
            sel_wdata[b] = '0;
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (gnt_id[b] == PW'(p)) begin
                    sel_we[b]    = p_we[p];
                    sel_addr[b]  = p_addr[p*ADDR_W +: ADDR_W];
                    sel_wdata[b] = p_wdata[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Bank issue, pointer advance and read-tag shift registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_en    <= '0;
            bank_we    <= '0;
            bank_addr  <= '0;
            bank_wdata <= '0;
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                rr_ptr[b] <= '0;
                for (int k = 0; k < int'(TD); k++) begin
                    tag_vld[b][k] <= 1'b0;
                    tag_id[b][k]  <= '0;
                end
            end
        end else begin
            bank_en <= gnt_vld;
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                bank_we[b]    <= gnt_vld[b] && sel_we[b];
                tag_vld[b][0] <= gnt_vld[b] && !sel_we[b];
                tag_id[b][0]  <= gnt_id[b];
                for (int k = 1; k < int'(TD); k++) begin
                    tag_vld[b][k] <= tag_vld[b][k-1];
                    tag_id[b][k]  <= tag_id[b][k-1];
                end
                if (gnt_vld[b]) begin
                    bank_addr[b*ADDR_W +: ADDR_W]  <= sel_addr[b];
                    bank_wdata[b*DATA_W +: DATA_W] <= sel_wdata[b];
                    rr_ptr[b] <= (gnt_id[b] == PW'(NUM_PORTS - 1)) ? '0 : gnt_id[b] + 1'b1;
                end
            end
        end
    end

    // Route each bank's returning word to the port recorded in the oldest tag.
    always_comb begin
        rv_nxt = '0;
        rd_nxt = p_rdata;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (tag_vld[b][TD-1] && tag_id[b][TD-1] == PW'(p)) begin
                    rv_nxt[p] = 1'b1;
                    rd_nxt[p*DATA_W +: DATA_W] = bank_rdata[b*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_rvalid <= '0;
            p_rdata  <= '0;
        end else begin
            p_rvalid <= rv_nxt;
            p_rdata  <= rd_nxt;
        end
    end

    always_comb begin
        stall  = p_req & ~p_ready;
        nstall = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            nstall = nstall + KW'(stall[p]);
        end
        csum = SW'(conflict_cnt) + SW'(nstall);
    end

    // Stall counter: clear wins, otherwise add stalls and saturate at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (clr_cnt) begin
            conflict_cnt <= '0;
        end else if (csum[CNT_W]) begin
            conflict_cnt <= '1;
        end else begin
            conflict_cnt <= csum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Bench for sram_bank_arbiter: a default instance checked every cycle against a
// transaction-level model, plus a small instance (2 ports, 4 banks, latency 3, 4-bit count).
module tb_sram_bank_arbiter;

    localparam int NP = 4, NB = 8, AW = 16, DW = 32, LAT = 1, CW = 16;
    localparam int NP2 = 2, NB2 = 4, LAT2 = 3, CW2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [NP-1:0]    p_req, p_we, p_ready, p_rvalid;
    logic [NP*3-1:0]  p_bank;
    logic [NP*AW-1:0] p_addr;
    logic [NP*DW-1:0] p_wdata, p_rdata;
    logic [NB-1:0]    bank_en, bank_we;
    logic [NB*AW-1:0] bank_addr;
    logic [NB*DW-1:0] bank_wdata, bank_rdata;
    logic [CW-1:0]    conflict_cnt;
    logic             clr_cnt;

    logic [NP2-1:0]     q_req, q_we, q_ready, q_rvalid;
    logic [NP2*2-1:0]   q_bank;
    logic [NP2*AW-1:0]  q_addr;
    logic [NP2*DW-1:0]  q_wdata, q_rdata;
    logic [NB2-1:0]     q_bank_en, q_bank_we;
    logic [NB2*AW-1:0]  q_bank_addr;
    logic [NB2*DW-1:0]  q_bank_wdata, q_bank_rdata;
    logic [CW2-1:0]     q_cnt;
    logic               q_clr;

    sram_bank_arbiter #(.NUM_PORTS(NP), .NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW),
                        .BANK_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .p_req(p_req), .p_we(p_we), .p_bank(p_bank),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_ready(p_ready), .p_rvalid(p_rvalid),
        .p_rdata(p_rdata), .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .conflict_cnt(conflict_cnt),
        .clr_cnt(clr_cnt));

    sram_bank_arbiter #(.NUM_PORTS(NP2), .NUM_BANKS(NB2), .ADDR_W(AW), .DATA_W(DW),
                        .BANK_LAT(LAT2), .CNT_W(CW2)) dut2 (
        .clk(clk), .rst(rst), .p_req(q_req), .p_we(q_we), .p_bank(q_bank),
        .p_addr(q_addr), .p_wdata(q_wdata), .p_ready(q_ready), .p_rvalid(q_rvalid),
        .p_rdata(q_rdata), .bank_en(q_bank_en), .bank_we(q_bank_we), .bank_addr(q_bank_addr),
        .bank_wdata(q_bank_wdata), .bank_rdata(q_bank_rdata), .conflict_cnt(q_cnt),
        .clr_cnt(q_clr));

    function automatic int key(input int b, input int a);
        return b * 65536 + a;
    endfunction

    // SRAM bank models: real storage for the default instance, address echo for the small one.
    logic [DW-1:0] sram [int];
    logic [DW-1:0] rd1 [NB];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_en[b]) begin
                if (bank_we[b]) sram[key(b, int'(bank_addr[b*AW +: AW]))] = bank_wdata[b*DW +: DW];
                else rd1[b] <= sram.exists(key(b, int'(bank_addr[b*AW +: AW]))) ?
                               sram[key(b, int'(bank_addr[b*AW +: AW]))] : '0;
            end
        end
    end
    always_comb for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = rd1[b];

    logic [AW-1:0] st2 [NB2][LAT2];
    always @(posedge clk) begin
        for (int b = 0; b < NB2; b++) begin
            st2[b][0] <= q_bank_addr[b*AW +: AW];
            for (int k = 1; k < LAT2; k++) st2[b][k] <= st2[b][k-1];
        end
    end
    always_comb for (int b = 0; b < NB2; b++)
        q_bank_rdata[b*DW +: DW] = 32'hB000_0000 | (32'(b) << 16) | 32'(st2[b][LAT2-1]);

    int ntests = 0, nfail = 0, cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stimulus state
    logic [NP-1:0] s_req, s_we;
    int            s_bank [NP];
    int            s_addr [NP];
    logic [31:0]   s_wd   [NP];
    logic          s_clr, s_rst;
    logic [NP2-1:0] t_req, t_we;
    int            t_bank [NP2];
    int            t_addr [NP2];
    logic          t_clr;

    // Reference model state
    typedef struct { int due; int port; logic [31:0] data; } ret_t;
    ret_t        rq [$];
    int          mptr [NB];
    logic [31:0] last_rd [NP];
    logic [31:0] refm [int];
    int          mcnt;
    logic [NB-1:0] pv_en;
    logic        pv_we [NB];
    int          pv_addr [NB];
    logic [31:0] pv_wd [NB];
    logic [NP-1:0] last_gnt;

    task automatic model_check();
        logic [NP-1:0] exp_rv, exp_rdy;
        int gb [NB];
        int best, bd, d, k, i;
        if (!rst) begin
            for (int b = 0; b < NB; b++) mptr[b] = 0;
            for (int p = 0; p < NP; p++) last_rd[p] = '0;
            rq.delete();
            mcnt = 0;
            pv_en = '0;
        end
        exp_rv = '0;
        i = 0;
        while (i < rq.size()) begin
            if (rq[i].due == cyc) begin
                exp_rv[rq[i].port] = 1'b1;
                last_rd[rq[i].port] = rq[i].data;
                rq.delete(i);
            end else i++;
        end
        chk($sformatf("rvalid@%0d", cyc), 64'(p_rvalid), 64'(exp_rv));
        for (int p = 0; p < NP; p++)
            chk($sformatf("rdata%0d@%0d", p, cyc), 64'(p_rdata[p*DW +: DW]), 64'(last_rd[p]));
        chk($sformatf("bank_en@%0d", cyc), 64'(bank_en), 64'(pv_en));
        for (int b = 0; b < NB; b++) begin
            if (pv_en[b]) begin
                chk($sformatf("bank_we%0d@%0d", b, cyc), 64'(bank_we[b]), 64'(pv_we[b]));
                chk($sformatf("bank_addr%0d@%0d", b, cyc), 64'(bank_addr[b*AW +: AW]), 64'(pv_addr[b]));
                if (pv_we[b])
                    chk($sformatf("bank_wdata%0d@%0d", b, cyc), 64'(bank_wdata[b*DW +: DW]), 64'(pv_wd[b]));
            end
        end
        chk($sformatf("conflict_cnt@%0d", cyc), 64'(conflict_cnt), 64'(mcnt));
        // Winner per bank: requester with smallest forward distance from the pointer.
        exp_rdy = '0;
        for (int b = 0; b < NB; b++) begin
            gb[b] = -1;
            if (rst) begin
                bd = NP;
                for (int p = 0; p < NP; p++) begin
                    if (s_req[p] && s_bank[p] == b) begin
                        d = (p - mptr[b] + NP) % NP;
                        if (d < bd) begin bd = d; gb[b] = p; end
                    end
                end
                if (gb[b] >= 0) exp_rdy[gb[b]] = 1'b1;
            end
        end
        chk($sformatf("ready@%0d", cyc), 64'(p_ready), 64'(exp_rdy));
        if (rst) begin
            pv_en = '0;
            for (int b = 0; b < NB; b++) begin
                if (gb[b] >= 0) begin
                    pv_en[b] = 1'b1;
                    pv_we[b] = s_we[gb[b]];
                    pv_addr[b] = s_addr[gb[b]];
                    pv_wd[b] = s_wd[gb[b]];
                    mptr[b] = (gb[b] + 1) % NP;
                    if (s_we[gb[b]]) refm[key(b, s_addr[gb[b]])] = s_wd[gb[b]];
                    else rq.push_back('{cyc + 2 + LAT, gb[b],
                         refm.exists(key(b, s_addr[gb[b]])) ? refm[key(b, s_addr[gb[b]])] : 32'h0});
                end
            end
            k = 0;
            for (int p = 0; p < NP; p++) if (s_req[p] && !exp_rdy[p]) k++;
            if (s_clr) mcnt = 0;
            else mcnt = (mcnt + k > (1 << CW) - 1) ? (1 << CW) - 1 : mcnt + k;
        end
        last_gnt = exp_rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst = s_rst;
        for (int p = 0; p < NP; p++) begin
            p_req[p] = s_req[p];
            p_we[p]  = s_we[p];
            p_bank[p*3 +: 3]   = 3'(s_bank[p]);
            p_addr[p*AW +: AW] = 16'(s_addr[p]);
            p_wdata[p*DW +: DW] = s_wd[p];
        end
        clr_cnt = s_clr;
        for (int p = 0; p < NP2; p++) begin
            q_req[p] = t_req[p];
            q_we[p]  = t_we[p];
            q_bank[p*2 +: 2]    = 2'(t_bank[p]);
            q_addr[p*AW +: AW]  = 16'(t_addr[p]);
            q_wdata[p*DW +: DW] = '0;
        end
        q_clr = t_clr;
        @(negedge clk);
        model_check();
        cyc++;
    endtask

    task automatic gen();
        for (int p = 0; p < NP; p++) begin
            if (!s_req[p] || last_gnt[p]) begin
                s_req[p]  = ($urandom_range(0, 3) != 0);
                s_bank[p] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 1));
                s_addr[p] = int'($urandom_range(0, 7));
                s_we[p]   = 1'($urandom_range(0, 1));
                s_wd[p]   = $urandom;
            end
        end
        s_clr = ($urandom_range(0, 49) == 0);
    endtask

    int c0;

    initial begin
        rst = 1'b0;
        s_rst = 1'b0; s_clr = 1'b0; t_clr = 1'b0;
        s_req = '0; s_we = '0; t_req = '0; t_we = '0;
        last_gnt = '0; mcnt = 0; pv_en = '0;
        for (int p = 0; p < NP; p++) begin s_bank[p] = p; s_addr[p] = 5; s_wd[p] = '0; last_rd[p] = '0; end
        for (int p = 0; p < NP2; p++) begin t_bank[p] = 0; t_addr[p] = 0; end
        for (int b = 0; b < NB; b++) begin rd1[b] = '0; mptr[b] = 0; end
        for (int b = 0; b < NB2; b++) for (int k = 0; k < LAT2; k++) st2[b][k] = '0;
        for (int i = 0; i < 4; i++) begin
            sram[key(i, 5)] = 32'hA0 + 32'(i);
            refm[key(i, 5)] = 32'hA0 + 32'(i);
        end

        // Reset held with all ports requesting
        s_req = 4'b1111;
        repeat (3) step();
        chk("rst_bank_addr", 64'(|bank_addr), 64'h0);
        chk("rst_bank_wdata", 64'(|bank_wdata), 64'h0);
        chk("rst_q_outputs", 64'({q_ready, q_rvalid, q_bank_en, q_cnt}), 64'h0);

        // Parallel reads to banks 0..3 granted on release
        s_rst = 1'b1;
        step();
        chk("par_ready", 64'(p_ready), 64'hF);
        s_req = '0;
        repeat (3) step();
        chk("par_rvalid", 64'(p_rvalid), 64'hF);
        for (int p = 0; p < NP; p++) chk($sformatf("par_rdata%0d", p), 64'(p_rdata[p*DW +: DW]), 64'hA0 + 64'(p));
        chk("par_cnt", 64'(conflict_cnt), 64'h0);

        // Reset pulse, then all ports contend for bank 2
        s_rst = 1'b0;
        step();
        s_rst = 1'b1;
        s_req = 4'b1111;
        for (int p = 0; p < NP; p++) begin s_bank[p] = 2; s_addr[p] = p + 1; s_we[p] = 1'b0; end
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) c0 = int'(conflict_cnt);
            if (i == 2) chk("rr_cnt_plus6", 64'(conflict_cnt), 64'(c0 + 6));
            chk($sformatf("rr_order%0d", i), 64'(p_ready), 64'(1 << (i % 4)));
        end

        // Write then read back on port 1
        s_req = 4'b0010;
        s_we[1] = 1'b1; s_bank[1] = 7; s_addr[1] = 16'h0010; s_wd[1] = 32'hDEADBEEF;
        step();
        chk("wr_ready", 64'(p_ready), 64'h2);
        s_we[1] = 1'b0;
        step();
        s_req = '0;
        repeat (3) step();
        chk("rd_back_valid", 64'(p_rvalid[1]), 64'h1);
        chk("rd_back_data", 64'(p_rdata[DW +: DW]), 64'hDEADBEEF);

        // Randomized traffic with hold-until-ready
        repeat (400) begin
            gen();
            step();
        end
        s_req = '0; s_clr = 1'b0;
        repeat (4) step();

        // Small instance: read latency 5 cycles
        t_req = 2'b01; t_we = '0; t_bank[0] = 1; t_addr[0] = 16'h33;
        step();
        chk("lat5_ready", 64'(q_ready), 64'h1);
        t_req = '0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("lat5_quiet%0d", i), 64'(q_rvalid), 64'h0);
        end
        step();
        chk("lat5_rvalid", 64'(q_rvalid), 64'h1);
        chk("lat5_rdata", 64'(q_rdata[DW-1:0]), 64'hB001_0033);

        // Pointer wraps modulo 2
        t_req = 2'b11; t_bank[0] = 2; t_bank[1] = 2; t_addr[0] = 16'h40; t_addr[1] = 16'h41;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("wrap%0d", i), 64'(q_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        t_req = '0;

        // Saturation at 15 and clear
        t_clr = 1'b1;
        step();
        t_clr = 1'b0; t_req = 2'b11; t_bank[0] = 3; t_bank[1] = 3;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 10) chk("cnt_mid", 64'(q_cnt), 64'd9);
        end
        chk("cnt_sat", 64'(q_cnt), 64'd15);
        t_clr = 1'b1;
        step();
        chk("cnt_hold_clr", 64'(q_cnt), 64'd15);
        t_clr = 1'b0; t_req = '0;
        step();
        chk("cnt_cleared", 64'(q_cnt), 64'd0);

        // Reset one cycle after a read handshake drops the read
        t_req = 2'b10; t_bank[1] = 0; t_addr[1] = 16'h44;
        step();
        chk("rstrd_ready", 64'(q_ready), 64'h2);
        t_req = '0;
        s_rst = 1'b0;
        step();
        chk("rstrd_ready_in_rst", 64'(q_ready), 64'h0);
        step();
        s_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rstrd_quiet%0d", i), 64'(q_rvalid), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
